squeeze_layer_sequencer: RTL
============================

// Module: squeeze_layer_sequencer
// PURPOSE
//  Central sequencer for one squeeze/1x1-or-KxK conv layer of the fire pipeline.
//  Generates the weight-ROM address and BRAM/LUT bank select, the MAC enable and
//  accumulator-clear pulse, the output sample strobe and the layer-finish
//  handshake with the downstream RAM. Sits between the layer-start chain and the
//  MAC array; replaces the free-running counters inside each layer.
// PARAMETERS
//  CHIN        256   input channels per output pixel
//  KERNEL_DIM  3     kernel side; ACC_LEN = KERNEL_DIM**2*CHIN (MACs per pixel)
//  WOUT        16    output side; WOUT**2 output pixels per layer
//  BRAM_DEPTH  2048  weights at addr < BRAM_DEPTH come from BRAM, rest from LUT ROM
//  CLR_LAT     2     cycles from last-MAC address to clr_pulse (MAC pipe depth)
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      async reset, active high
//  start        in   1                      1-cycle layer start request
//  ifm_valid    in   1                      input pixel word valid this cycle
//  ram_feedback in   1                      downstream RAM acknowledges finish
//  weight_addr  out  $clog2(ACC_LEN)        weight ROM address for current MAC
//  rom_sel      out  1                      1 = LUT ROM, 0 = BRAM
//  mac_en       out  1                      MAC array enable (consume ifm/weight)
//  clr_pulse    out  1                      accumulator dump/clear, 1 cycle
//  sample       out  1                      ofm valid (clr_pulse delayed 1)
//  busy         out  1                      state != IDLE
//  layer_finish out  1                      layer done, held until ram_feedback
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; weight_addr=0; internal counters 0.
//  All outputs registered. States IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 -> RUN next cycle; counters cleared. ram_feedback ignored.
//  RUN: cycle with ifm_valid=1 -> mac_en=1 next cycle, weight_addr = k of that
//   MAC (0..ACC_LEN-1), rom_sel = (weight_addr >= BRAM_DEPTH) same cycle.
//   ifm_valid=0 -> mac_en=0, weight_addr holds (stall, no bubble in count).
//   After MAC k=ACC_LEN-1: weight_addr wraps to 0, pixel_cnt+1; clr_pulse
//   asserts exactly CLR_LAT cycles after that mac_en cycle, independent of
//   later stalls; sample asserts 1 cycle after clr_pulse.
//   Last MAC of pixel WOUT**2-1 -> DRAIN; further ifm_valid ignored.
//  DRAIN: wait until final sample has been issued -> DONE.
//  DONE: layer_finish=1 while ram_feedback=0; ram_feedback=1 -> layer_finish
//   0 and IDLE next cycle. Sample/clr never asserted in DONE.
//  start while busy: ignored. start and ram_feedback same cycle in DONE: IDLE
//   only; start dropped. Async rst mid-layer: immediate return to IDLE, pending
//   clr/sample pipe flushed (no pulse after reset).
//  pixel_cnt width $clog2(WOUT**2)+1; never wraps, saturates at WOUT**2.
//  Back-to-back pixels: clr_pulse spacing = ACC_LEN cycles with ifm_valid=1.
// TESTING
//  (use CHIN=2, KERNEL_DIM=1, WOUT=2, BRAM_DEPTH=1, CLR_LAT=2 unless noted)
//  1 start, ifm_valid=1 steady -> mac_en 8 cycles, weight_addr 0,1,0,1..,
//    rom_sel=weight_addr, 4 clr_pulse 2 cycles apart, 4 sample, then finish=1.
//  2 ifm_valid toggling 1,0 -> weight_addr holds on 0 cycles; exactly 4 clr
//    pulses; each clr exactly 2 cycles after the addr=1 mac_en cycle.
//  3 finish=1, ram_feedback held 0 for 10 cycles -> finish stays 1, busy=1;
//    ram_feedback=1 -> finish=0, busy=0 next cycle.
//  4 start pulsed during RUN and DONE -> no restart, counts unchanged.
//  5 rst asserted 1 cycle after a last-MAC cycle -> no clr_pulse/sample,
//    all outputs 0; new start runs a full clean layer.
//  6 defaults (ACC_LEN=2304) -> rom_sel 0 for addr 0..2047, 1 for 2048..2303;
//    256 clr_pulse total before layer_finish.

Source files
------------

// File: rtl/squeeze_layer_sequencer.sv
// Sequencer for one squeeze/conv layer: weight addressing, MAC enable, accumulator
// clear/sample strobes and the layer-finish handshake with the downstream RAM.
module squeeze_layer_sequencer #(
    parameter int CHIN       = 256,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 16,
    parameter int BRAM_DEPTH = 2048,
    parameter int CLR_LAT    = 2,
    localparam int ACC_LEN   = KERNEL_DIM * KERNEL_DIM * CHIN,
    localparam int AW        = $clog2(ACC_LEN),
    localparam int NPIX      = WOUT * WOUT,
    localparam int PW        = $clog2(NPIX) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ifm_valid,
    input  logic          ram_feedback,
    output logic [AW-1:0] weight_addr,
    output logic          rom_sel,
    output logic          mac_en,
    output logic          clr_pulse,
    output logic          sample,
    output logic          busy,
    output logic          layer_finish
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] k_cnt;
    logic [PW-1:0] pixel_cnt;
    // Bit 0 marks the mac_en cycle of a pixel's last MAC; clr_pulse is the tail.
    logic [CLR_LAT:0] clr_pipe;

    logic issue;
    logic issue_last;
    logic final_pix;

    assign issue      = (state == RUN) && ifm_valid;
    assign issue_last = issue && (k_cnt == AW'(ACC_LEN - 1));
    assign final_pix  = (pixel_cnt == PW'(NPIX - 1));
    assign clr_pulse  = clr_pipe[CLR_LAT];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue_last && final_pix) state_nx = DRAIN;
            // Earlier pixels' samples may still be in flight; wait for an empty pipe.
            DRAIN:   if (sample && !(|clr_pipe)) state_nx = DONE;
            DONE:    if (ram_feedback) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k_cnt        <= '0;
            pixel_cnt    <= '0;
            clr_pipe     <= '0;
            weight_addr  <= '0;
            rom_sel      <= 1'b0;
            mac_en       <= 1'b0;
            sample       <= 1'b0;
            busy         <= 1'b0;
            layer_finish <= 1'b0;
        end else begin
            state        <= state_nx;
            mac_en       <= issue;
            busy         <= (state_nx != IDLE);
            layer_finish <= (state_nx == DONE);
            clr_pipe     <= {clr_pipe[CLR_LAT-1:0], issue_last};
            sample       <= clr_pipe[CLR_LAT];

            if (state == IDLE && start) begin
                k_cnt       <= '0;
                pixel_cnt   <= '0;
                weight_addr <= '0;
                rom_sel     <= 1'b0;
            end else if (issue) begin
                weight_addr <= k_cnt;
                rom_sel     <= ({{(32-AW){1'b0}}, k_cnt} >= 32'(BRAM_DEPTH));
                if (issue_last) begin
                    k_cnt <= '0;
                    if (pixel_cnt < PW'(NPIX))
                        pixel_cnt <= pixel_cnt + PW'(1);
                end else begin
                    k_cnt <= k_cnt + AW'(1);
                end
            end
        end
    end

endmodule
